// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_pkg
// Description : Shared definitions for the pipeline control unit.
//               - opcode / funct encodings recognised in ID
//               - bit positions inside the control word
//                 {RegDst,ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,
//                  Branch,Jump,ALUOp[1:0]}
//               - the decoded control word for every supported opcode
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Opcode / funct encodings
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_fn_mult  = 6'b011000;

    // Control word layout
    localparam int c_ctrl_w        = 10;
    localparam int c_bit_regdst    = 9;
    localparam int c_bit_alusrc    = 8;
    localparam int c_bit_memtoreg  = 7;
    localparam int c_bit_regwrite  = 6;
    localparam int c_bit_memread   = 5;
    localparam int c_bit_memwrite  = 4;
    localparam int c_bit_branch    = 3;
    localparam int c_bit_jump      = 2;
    localparam int c_bit_aluop_hi  = 1;
    localparam int c_bit_aluop_lo  = 0;

    // Decoded control words
    localparam logic [c_ctrl_w-1:0] c_ctrl_nop   = 10'b0000000000;
    localparam logic [c_ctrl_w-1:0] c_ctrl_rtype = 10'b1001000010;
    localparam logic [c_ctrl_w-1:0] c_ctrl_lw    = 10'b0111100000;
    localparam logic [c_ctrl_w-1:0] c_ctrl_sw    = 10'b0100010000;
    localparam logic [c_ctrl_w-1:0] c_ctrl_beq   = 10'b0000001001;
    localparam logic [c_ctrl_w-1:0] c_ctrl_addi  = 10'b0101000000;
    localparam logic [c_ctrl_w-1:0] c_ctrl_j     = 10'b0000000100;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Purely combinational ID-stage decoder. Maps opcode/funct to
//               the control word, flags opcodes outside the supported set,
//               and recognises the multi-cycle MULT (R-type, funct 011000).
// Ports       : i_opcode  - instr[31:26]
//               i_funct   - instr[5:0]
//               o_ctrl    - decoded control word (all-zero for a bubble)
//               o_illegal - opcode not recognised
//               o_is_mult - instruction is MULT
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import pipe_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int CTRL_W   = 10
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [OPCODE_W-1:0] i_funct,
    output logic [CTRL_W-1:0]   o_ctrl,
    output logic                o_illegal,
    output logic                o_is_mult
);

    always_comb begin
        o_ctrl    = CTRL_W'(c_ctrl_nop);
        o_illegal = 1'b0;
        o_is_mult = 1'b0;
        case (i_opcode)
            OPCODE_W'(c_op_rtype): begin
                o_ctrl    = CTRL_W'(c_ctrl_rtype);
                o_is_mult = (i_funct == OPCODE_W'(c_fn_mult));
            end
            OPCODE_W'(c_op_lw):   o_ctrl = CTRL_W'(c_ctrl_lw);
            OPCODE_W'(c_op_sw):   o_ctrl = CTRL_W'(c_ctrl_sw);
            OPCODE_W'(c_op_beq):  o_ctrl = CTRL_W'(c_ctrl_beq);
            OPCODE_W'(c_op_addi): o_ctrl = CTRL_W'(c_ctrl_addi);
            OPCODE_W'(c_op_j):    o_ctrl = CTRL_W'(c_ctrl_j);
            default:              o_illegal = 1'b1;
        endcase
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_unit
// Description : Pipeline control unit. Decodes the ID instruction and carries
//               its control word through ID/EX, EX/MEM and MEM/WB. Inserts a
//               bubble on a load-use hazard, holds ID/EX while a MULT
//               occupies EX for MUL_CYCLES cycles, and squashes ID and EX on
//               a taken branch.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               opcode, funct     - ID instruction fields
//               id_rs, id_rt      - ID source register specifiers
//               flush             - branch taken, squash ID and EX
//               ex_ctrl/mem_ctrl/wb_ctrl - stage control words
//               pc_write, ifid_write     - front-end enables (combinational)
//               mul_busy          - MULT holding EX (registered)
//               illegal_op        - one-cycle pulse, bad opcode into ID/EX
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit
    import pipe_pkg::*;
#(
    parameter int OPCODE_W   = 6,
    parameter int REG_W      = 5,
    parameter int CTRL_W     = 10,
    parameter int MUL_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [OPCODE_W-1:0] funct,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                flush,
    output logic [CTRL_W-1:0]   ex_ctrl,
    output logic [CTRL_W-1:0]   mem_ctrl,
    output logic [CTRL_W-1:0]   wb_ctrl,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                mul_busy,
    output logic                illegal_op
);

    localparam int c_cnt_w = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [0:0] c_st_run      = 1'b0;
    localparam logic [0:0] c_st_mul_busy = 1'b1;

    // Registered state
    logic [0:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [CTRL_W-1:0]  r_ex_ctrl;
    logic [REG_W-1:0]   r_ex_rt;
    logic [CTRL_W-1:0]  r_mem_ctrl;
    logic [CTRL_W-1:0]  r_wb_ctrl;
    logic               r_illegal;

    // Next-state values
    logic [0:0]         w_nxt_state;
    logic [c_cnt_w-1:0] w_nxt_cnt;
    logic [CTRL_W-1:0]  w_nxt_ex_ctrl;
    logic [REG_W-1:0]   w_nxt_ex_rt;
    logic [CTRL_W-1:0]  w_nxt_mem_ctrl;
    logic [CTRL_W-1:0]  w_nxt_wb_ctrl;
    logic               w_nxt_illegal;
    logic               w_front_en;

    // Decoder outputs
    logic [CTRL_W-1:0]  w_dec_ctrl;
    logic               w_dec_illegal;
    logic               w_dec_is_mult;

    logic               w_busy;
    logic               w_lu;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .CTRL_W   (CTRL_W)
    ) u_decode (
        .i_opcode  (opcode),
        .i_funct   (funct),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal),
        .o_is_mult (w_dec_is_mult)
    );

    assign w_busy = (r_state == c_st_mul_busy);

    // A load into r0 never creates a dependency: r0 is hard-wired to zero.
    assign w_lu = r_ex_ctrl[c_bit_memread]
                & (r_ex_rt != '0)
                & ((r_ex_rt == id_rs) | (r_ex_rt == id_rt));

    // Next-state / output logic. The if-chain order encodes the priority
    // flush > MUL hold > load-use > normal advance; reset sits on top in the
    // register process.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_cnt      = r_cnt;
        w_nxt_ex_ctrl  = w_dec_ctrl;
        w_nxt_ex_rt    = id_rt;
        w_nxt_mem_ctrl = r_ex_ctrl;
        w_nxt_wb_ctrl  = r_mem_ctrl;
        w_nxt_illegal  = w_dec_illegal;
        w_front_en     = 1'b1;

        if (flush) begin
            // The fetch unit loads the branch target, so the front end runs.
            w_nxt_ex_ctrl  = '0;
            w_nxt_ex_rt    = '0;
            w_nxt_mem_ctrl = '0;
            w_nxt_illegal  = 1'b0;
            w_nxt_state    = c_st_run;
            w_nxt_cnt      = '0;
        end else if (w_busy) begin
            // MULT keeps EX: ID/EX holds, EX/MEM receives bubbles.
            w_nxt_ex_ctrl  = r_ex_ctrl;
            w_nxt_ex_rt    = r_ex_rt;
            w_nxt_mem_ctrl = '0;
            w_nxt_illegal  = 1'b0;
            w_front_en     = 1'b0;
            w_nxt_cnt      = r_cnt - c_cnt_w'(1);
            if (r_cnt == c_cnt_w'(1)) begin
                w_nxt_state = c_st_run;
            end
        end else if (w_lu) begin
            w_nxt_ex_ctrl  = '0;
            w_nxt_ex_rt    = '0;
            w_nxt_illegal  = 1'b0;
            w_front_en     = 1'b0;
        end else if (w_dec_is_mult && (MUL_CYCLES > 1)) begin
            // The entry edge is the first of MUL_CYCLES cycles in EX.
            w_nxt_state = c_st_mul_busy;
            w_nxt_cnt   = c_cnt_w'(MUL_CYCLES - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_run;
            r_cnt      <= '0;
            r_ex_ctrl  <= '0;
            r_ex_rt    <= '0;
            r_mem_ctrl <= '0;
            r_wb_ctrl  <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_ex_ctrl  <= w_nxt_ex_ctrl;
            r_ex_rt    <= w_nxt_ex_rt;
            r_mem_ctrl <= w_nxt_mem_ctrl;
            r_wb_ctrl  <= w_nxt_wb_ctrl;
            r_illegal  <= w_nxt_illegal;
        end
    end

    assign ex_ctrl    = r_ex_ctrl;
    assign mem_ctrl   = r_mem_ctrl;
    assign wb_ctrl    = r_wb_ctrl;
    assign pc_write   = w_front_en;
    assign ifid_write = w_front_en;
    assign mul_busy   = w_busy;
    assign illegal_op = r_illegal;

endmodule : pipe_ctrl_unit
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl_unit
// Description : Directed bench for pipe_ctrl_unit. Each row drives one cycle
//               of ID inputs and queues the outputs expected during that
//               cycle; a monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_MUL   = 6'b011000;

    localparam logic [9:0] K_0    = 10'b0000000000;
    localparam logic [9:0] K_R    = 10'b1001000010;
    localparam logic [9:0] K_LW   = 10'b0111100000;
    localparam logic [9:0] K_SW   = 10'b0100010000;
    localparam logic [9:0] K_BEQ  = 10'b0000001001;
    localparam logic [9:0] K_ADDI = 10'b0101000000;
    localparam logic [9:0] K_J    = 10'b0000000100;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       flush;
    logic [9:0] ex_ctrl;
    logic [9:0] mem_ctrl;
    logic [9:0] wb_ctrl;
    logic       pc_write;
    logic       ifid_write;
    logic       mul_busy;
    logic       illegal_op;

    typedef struct {
        int         id;
        logic [9:0] ex;
        logic [9:0] mem;
        logic [9:0] wb;
        logic       pc;
        logic       busy;
        logic       ill;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   row_id   = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(
        .OPCODE_W   (6),
        .REG_W      (5),
        .CTRL_W     (10),
        .MUL_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .flush      (flush),
        .ex_ctrl    (ex_ctrl),
        .mem_ctrl   (mem_ctrl),
        .wb_ctrl    (wb_ctrl),
        .pc_write   (pc_write),
        .ifid_write (ifid_write),
        .mul_busy   (mul_busy),
        .illegal_op (illegal_op)
    );

    task automatic chk(input int id, input string name, input logic [9:0] act, input logic [9:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL row %0d %s: got %b expected %b", id, name, act, req);
        end
    endtask

    // Monitor: outputs are stable half a cycle after the inputs change.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.id, "ex_ctrl",    ex_ctrl,           e.ex);
            chk(e.id, "mem_ctrl",   mem_ctrl,          e.mem);
            chk(e.id, "wb_ctrl",    wb_ctrl,           e.wb);
            chk(e.id, "pc_write",   {9'd0, pc_write},  {9'd0, e.pc});
            chk(e.id, "ifid_write", {9'd0, ifid_write},{9'd0, e.pc});
            chk(e.id, "mul_busy",   {9'd0, mul_busy},  {9'd0, e.busy});
            chk(e.id, "illegal_op", {9'd0, illegal_op},{9'd0, e.ill});
        end
    end

    // One cycle: drive inputs, queue the outputs expected in this cycle.
    task automatic row(input logic rs_i, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic fl,
                       input logic [9:0] e_ex, input logic [9:0] e_mem, input logic [9:0] e_wb,
                       input logic e_pc, input logic e_busy, input logic e_ill);
        exp_t e;
        reset  = rs_i;
        opcode = op;
        funct  = fn;
        id_rs  = rs;
        id_rt  = rt;
        flush  = fl;
        e.id = row_id; e.ex = e_ex; e.mem = e_mem; e.wb = e_wb;
        e.pc = e_pc; e.busy = e_busy; e.ill = e_ill;
        q.push_back(e);
        row_id++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = OP_J; funct = '0; id_rs = '0; id_rt = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        //   rst op       fn     rs  rt  fl  ex      mem     wb      pc busy ill
        row(1, OP_J,    F_ADD, 0,  0,  0, K_0,    K_0,    K_0,    1, 0, 0); // 0 reset state
        row(0, OP_J,    F_ADD, 0,  0,  0, K_0,    K_0,    K_0,    1, 0, 0); // 1
        row(0, OP_LW,   F_ADD, 2,  1,  0, K_J,    K_0,    K_0,    1, 0, 0); // 2 lw r1
        row(0, OP_R,    F_ADD, 1,  3,  0, K_LW,   K_J,    K_0,    0, 0, 0); // 3 add uses r1 -> stall
        row(0, OP_R,    F_ADD, 1,  3,  0, K_0,    K_LW,   K_J,    1, 0, 0); // 4 bubble in EX
        row(0, OP_LW,   F_ADD, 0,  0,  0, K_R,    K_0,    K_LW,   1, 0, 0); // 5 add in EX; lw r0
        row(0, OP_R,    F_ADD, 0,  3,  0, K_LW,   K_R,    K_0,    1, 0, 0); // 6 r0 -> no stall
        row(0, OP_LW,   F_ADD, 0,  5,  0, K_R,    K_LW,   K_R,    1, 0, 0); // 7 lw r5
        row(0, OP_SW,   F_ADD, 4,  5,  0, K_LW,   K_R,    K_LW,   0, 0, 0); // 8 sw rt=r5 -> stall
        row(0, OP_SW,   F_ADD, 4,  5,  0, K_0,    K_LW,   K_R,    1, 0, 0); // 9
        row(0, OP_R,    F_MUL, 6,  7,  0, K_SW,   K_0,    K_LW,   1, 0, 0); // 10 MULT into ID
        row(0, OP_ADDI, F_ADD, 7,  8,  0, K_R,    K_SW,   K_0,    0, 1, 0); // 11 busy cnt3
        row(0, OP_ADDI, F_ADD, 7,  8,  0, K_R,    K_0,    K_SW,   0, 1, 0); // 12 busy cnt2
        row(0, OP_ADDI, F_ADD, 7,  8,  0, K_R,    K_0,    K_0,    0, 1, 0); // 13 busy cnt1
        row(0, OP_ADDI, F_ADD, 7,  8,  0, K_R,    K_0,    K_0,    1, 0, 0); // 14 4th EX cycle
        row(0, OP_BEQ,  F_ADD, 1,  2,  0, K_ADDI, K_R,    K_0,    1, 0, 0); // 15
        row(0, OP_BAD,  F_ADD, 0,  0,  0, K_BEQ,  K_ADDI, K_R,    1, 0, 0); // 16 illegal opcode
        row(0, OP_J,    F_ADD, 0,  0,  0, K_0,    K_BEQ,  K_ADDI, 1, 0, 1); // 17 pulse
        row(0, OP_J,    F_ADD, 0,  0,  0, K_J,    K_0,    K_BEQ,  1, 0, 0); // 18 pulse over
        row(0, OP_R,    F_MUL, 1,  2,  0, K_J,    K_J,    K_0,    1, 0, 0); // 19 MULT
        row(0, OP_ADDI, F_ADD, 3,  4,  0, K_R,    K_J,    K_J,    0, 1, 0); // 20 busy cnt3
        row(0, OP_ADDI, F_ADD, 3,  4,  1, K_R,    K_0,    K_J,    1, 1, 0); // 21 flush at cnt2
        row(0, OP_ADDI, F_ADD, 3,  4,  0, K_0,    K_0,    K_0,    1, 0, 0); // 22 squashed
        row(0, OP_LW,   F_ADD, 0,  9,  0, K_ADDI, K_0,    K_0,    1, 0, 0); // 23 lw r9
        row(0, OP_R,    F_ADD, 9,  3,  1, K_LW,   K_ADDI, K_0,    1, 0, 0); // 24 lu + flush
        row(0, OP_J,    F_ADD, 0,  0,  0, K_0,    K_0,    K_ADDI, 1, 0, 0); // 25
        row(0, OP_R,    F_MUL, 1,  2,  0, K_J,    K_0,    K_0,    1, 0, 0); // 26 MULT
        row(1, OP_ADDI, F_ADD, 3,  4,  0, K_R,    K_J,    K_0,    0, 1, 0); // 27 reset mid-busy
        row(0, OP_ADDI, F_ADD, 3,  4,  0, K_0,    K_0,    K_0,    1, 0, 0); // 28 cleared, RUN
        row(0, OP_J,    F_ADD, 0,  0,  0, K_ADDI, K_0,    K_0,    1, 0, 0); // 29 decode resumed
        row(0, OP_J,    F_ADD, 0,  0,  0, K_J,    K_ADDI, K_0,    1, 0, 0); // 30

        repeat (4) begin
            if (q.size() != 0) @(negedge clk);
        end
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_pipe_ctrl_unit
`default_nettype wire
